// File: rtl/virtual_ds2431_pkg.sv
// rtl/virtual_ds2431_pkg.sv - shared encodings and constants for the virtual DS2431 command engines
package virtual_ds2431_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RX_TA1 = 3'd1,
        ST_RX_TA2 = 3'd2,
        ST_RX_ES  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_PROG   = 3'd5,
        ST_TX_AA  = 3'd6
    } copy_state_t;

    localparam logic [7:0] CMD_COPY_SP  = 8'h55;
    localparam logic [7:0] AUTH_ES      = 8'h07;
    localparam logic [7:0] ROW_MAX_TA1  = 8'h87;
    localparam logic [7:0] AA_BYTE_DEF  = 8'hAA;
    localparam logic [7:0] BUS_IDLE     = 8'hFF;

    // Authorization: echoed TA1/TA2/E-S must match what Write Scratchpad stored,
    // the scratchpad must be full (E/S=7) and the target must be a real row.
    function automatic logic auth_ok(
        input logic [7:0] rx_ta1,
        input logic [7:0] rx_ta2,
        input logic [7:0] rx_es,
        input logic [7:0] ta1,
        input logic [7:0] ta2,
        input logic [2:0] es,
        input logic       wr_valid
    );
        return (rx_ta1 == ta1) && (rx_ta2 == ta2) && (rx_es == AUTH_ES) &&
               (es == 3'd7) && wr_valid && (ta2 == 8'h00) && (ta1 <= ROW_MAX_TA1);
    endfunction

endpackage

// File: rtl/posPulse.sv
// rtl/posPulse.sv - rising-edge detector producing a one-clk pulse
module posPulse (
    input  logic clk,
    input  logic nRst,
    input  logic i_sig,
    output logic o_pulse
);

    logic r_prev;

    // remember last level so the pulse fires only on a 0->1 change
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_pulse = i_sig & ~r_prev;

endmodule

// File: rtl/virtual_ds2431_prog_timer.sv
// rtl/virtual_ds2431_prog_timer.sv - tPROG counter, busy for exactly TPROG_CYCLES clks after start
module virtual_ds2431_prog_timer #(
    parameter int TPROG_CYCLES = 500000
) (
    input  logic clk,
    input  logic nRst,
    input  logic i_start,
    input  logic i_clear,
    output logic o_busy,
    output logic o_done
);

    localparam int CW = (TPROG_CYCLES > 1) ? $clog2(TPROG_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TPROG_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          r_busy;

    // count 0..TPROG_CYCLES-1 while busy; clear wins over start so an abort is final
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_count <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (r_count == LAST) begin
                r_busy <= 1'b0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_count == LAST);

endmodule

// File: rtl/virtual_ds2431_mem_copy_scratchpad.sv
// rtl/virtual_ds2431_mem_copy_scratchpad.sv - Copy Scratchpad (55h) command engine
module virtual_ds2431_mem_copy_scratchpad
    import virtual_ds2431_pkg::*;
#(
    parameter int         TPROG_CYCLES = 500000,
    parameter logic [7:0] AA_BYTE      = AA_BYTE_DEF
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        cmdRunTrig,
    input  logic        endCmd,
    input  logic [7:0]  TA1,
    input  logic [7:0]  TA2,
    input  logic [2:0]  ES,
    input  logic        wrSpValid,
    input  logic [63:0] Scratchpad,
    input  logic        clrAA,
    input  logic [7:0]  receiveDat,
    input  logic        ByteTransDone,
    output logic [7:0]  sentDat,
    output logic        nRxTx,
    output logic        transTrig,
    output logic        memWrEn,
    output logic [4:0]  memWrRow,
    output logic [63:0] memWrDat,
    output logic        aaFlag,
    output logic        cmdDone,
    output logic        cmdFailed
);

    copy_state_t r_state;
    logic [7:0]  r_ta1;
    logic [7:0]  r_ta2;
    logic        r_accept;

    logic w_runEdge;
    logic w_endEdge;
    logic w_doneEdge;
    logic w_authOk;
    logic w_timerStart;
    logic w_timerClear;
    logic w_timerBusy;
    logic w_timerDone;

    posPulse u_run_edge  (.clk(clk), .nRst(nRst), .i_sig(cmdRunTrig),    .o_pulse(w_runEdge));
    posPulse u_end_edge  (.clk(clk), .nRst(nRst), .i_sig(endCmd),        .o_pulse(w_endEdge));
    posPulse u_done_edge (.clk(clk), .nRst(nRst), .i_sig(ByteTransDone), .o_pulse(w_doneEdge));

    // E/S byte is judged straight off receiveDat on its done edge so the write strobe follows by one clk
    assign w_authOk     = auth_ok(r_ta1, r_ta2, receiveDat, TA1, TA2, ES, wrSpValid);
    assign w_timerStart = (r_state == ST_CHECK) && r_accept && !w_runEdge && !w_endEdge;
    assign w_timerClear = w_runEdge | w_endEdge;

    virtual_ds2431_prog_timer #(
        .TPROG_CYCLES(TPROG_CYCLES)
    ) u_prog_timer (
        .clk    (clk),
        .nRst   (nRst),
        .i_start(w_timerStart),
        .i_clear(w_timerClear),
        .o_busy (w_timerBusy),
        .o_done (w_timerDone)
    );

    // command FSM: start edge beats abort edge beats normal sequencing; clrAA beats an aaFlag set
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= ST_IDLE;
            r_ta1     <= 8'h00;
            r_ta2     <= 8'h00;
            r_accept  <= 1'b0;
            sentDat   <= BUS_IDLE;
            nRxTx     <= 1'b0;
            transTrig <= 1'b0;
            memWrEn   <= 1'b0;
            memWrRow  <= 5'd0;
            memWrDat  <= 64'd0;
            aaFlag    <= 1'b0;
            cmdDone   <= 1'b1;
            cmdFailed <= 1'b0;
        end else begin
            transTrig <= 1'b0;
            memWrEn   <= 1'b0;
            if (w_runEdge) begin
                r_state   <= ST_RX_TA1;
                cmdDone   <= 1'b0;
                cmdFailed <= 1'b0;
                nRxTx     <= 1'b0;
                sentDat   <= BUS_IDLE;
                transTrig <= 1'b1;
            end else if (w_endEdge) begin
                r_state <= ST_IDLE;
                nRxTx   <= 1'b0;
                sentDat <= BUS_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        nRxTx   <= 1'b0;
                        sentDat <= BUS_IDLE;
                    end
                    ST_RX_TA1: begin
                        if (w_doneEdge) begin
                            r_ta1     <= receiveDat;
                            r_state   <= ST_RX_TA2;
                            transTrig <= 1'b1;
                        end
                    end
                    ST_RX_TA2: begin
                        if (w_doneEdge) begin
                            r_ta2     <= receiveDat;
                            r_state   <= ST_RX_ES;
                            transTrig <= 1'b1;
                        end
                    end
                    ST_RX_ES: begin
                        if (w_doneEdge) begin
                            r_accept <= w_authOk;
                            r_state  <= ST_CHECK;
                            if (w_authOk) begin
                                memWrEn  <= 1'b1;
                                memWrRow <= TA1[7:3];
                                memWrDat <= Scratchpad;
                                aaFlag   <= 1'b1;
                            end else begin
                                cmdFailed <= 1'b1;
                                cmdDone   <= 1'b0;
                            end
                        end
                    end
                    ST_CHECK: begin
                        r_state <= r_accept ? ST_PROG : ST_IDLE;
                    end
                    ST_PROG: begin
                        // an idle timer here means the count was lost; leave rather than hang
                        if (w_timerDone || !w_timerBusy) begin
                            sentDat   <= AA_BYTE;
                            nRxTx     <= 1'b1;
                            transTrig <= 1'b1;
                            cmdDone   <= 1'b1;
                            r_state   <= ST_TX_AA;
                        end
                    end
                    ST_TX_AA: begin
                        if (w_doneEdge) begin
                            transTrig <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
            if (clrAA) begin
                aaFlag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_virtual_ds2431_mem_copy_scratchpad.sv
// tb/tb_virtual_ds2431_mem_copy_scratchpad.sv - randomized self-checking bench with event-schedule model
module tb_virtual_ds2431_mem_copy_scratchpad;

    localparam int T = 20;

    localparam int K_TRIG  = 0;
    localparam int K_WR    = 1;
    localparam int K_AA1   = 2;
    localparam int K_AA0   = 3;
    localparam int K_DONE1 = 4;
    localparam int K_DONE0 = 5;
    localparam int K_FAIL1 = 6;
    localparam int K_FAIL0 = 7;
    localparam int K_TX1   = 8;
    localparam int K_TX0   = 9;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        cmdRunTrig = 1'b0;
    logic        endCmd = 1'b0;
    logic [7:0]  TA1 = 8'h00;
    logic [7:0]  TA2 = 8'h00;
    logic [2:0]  ES = 3'd0;
    logic        wrSpValid = 1'b0;
    logic [63:0] Scratchpad = 64'd0;
    logic        clrAA = 1'b0;
    logic [7:0]  receiveDat = 8'h00;
    logic        ByteTransDone = 1'b0;
    logic [7:0]  sentDat;
    logic        nRxTx;
    logic        transTrig;
    logic        memWrEn;
    logic [4:0]  memWrRow;
    logic [63:0] memWrDat;
    logic        aaFlag;
    logic        cmdDone;
    logic        cmdFailed;

    virtual_ds2431_mem_copy_scratchpad #(
        .TPROG_CYCLES(T),
        .AA_BYTE     (8'hAA)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .cmdRunTrig   (cmdRunTrig),
        .endCmd       (endCmd),
        .TA1          (TA1),
        .TA2          (TA2),
        .ES           (ES),
        .wrSpValid    (wrSpValid),
        .Scratchpad   (Scratchpad),
        .clrAA        (clrAA),
        .receiveDat   (receiveDat),
        .ByteTransDone(ByteTransDone),
        .sentDat      (sentDat),
        .nRxTx        (nRxTx),
        .transTrig    (transTrig),
        .memWrEn      (memWrEn),
        .memWrRow     (memWrRow),
        .memWrDat     (memWrDat),
        .aaFlag       (aaFlag),
        .cmdDone      (cmdDone),
        .cmdFailed    (cmdFailed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int k;
    } ev_t;

    ev_t evq[$];
    ev_t keep_q[$];

    logic        m_aa = 1'b0;
    logic        m_done = 1'b1;
    logic        m_fail = 1'b0;
    logic        m_tx = 1'b0;
    logic [4:0]  m_row = 5'd0;
    logic [63:0] m_dat = 64'd0;
    logic        e_trig, e_wr, e_aa_set, e_aa_clr;

    int          cap_first_tx = -1;
    logic [4:0]  cap_row = 5'd0;
    logic [63:0] cap_dat = 64'd0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    function automatic void sched(input int c, input int k);
        ev_t e;
        e.c = c;
        e.k = k;
        evq.push_back(e);
    endfunction

    function automatic void cancel_from(input int c);
        ev_t kq[$];
        foreach (evq[i]) if (evq[i].c < c) kq.push_back(evq[i]);
        evq = kq;
    endfunction

    // compare process: apply this cycle's scheduled events to the model, then check every output
    always @(negedge clk) begin
        e_trig = 1'b0;
        e_wr = 1'b0;
        e_aa_set = 1'b0;
        e_aa_clr = 1'b0;
        keep_q.delete();
        foreach (evq[i]) begin
            if (evq[i].c == cyc) begin
                case (evq[i].k)
                    K_TRIG:  e_trig = 1'b1;
                    K_WR:    e_wr = 1'b1;
                    K_AA1:   e_aa_set = 1'b1;
                    K_AA0:   e_aa_clr = 1'b1;
                    K_DONE1: m_done = 1'b1;
                    K_DONE0: m_done = 1'b0;
                    K_FAIL1: m_fail = 1'b1;
                    K_FAIL0: m_fail = 1'b0;
                    K_TX1:   m_tx = 1'b1;
                    K_TX0:   m_tx = 1'b0;
                    default: ;
                endcase
            end else begin
                keep_q.push_back(evq[i]);
            end
        end
        evq = keep_q;
        if (e_aa_clr) m_aa = 1'b0;
        else if (e_aa_set) m_aa = 1'b1;
        if (cyc > 0) begin
            chk("transTrig", transTrig, e_trig);
            chk("memWrEn", memWrEn, e_wr);
            chk("aaFlag", aaFlag, m_aa);
            chk("cmdDone", cmdDone, m_done);
            chk("cmdFailed", cmdFailed, m_fail);
            chk("nRxTx", nRxTx, m_tx);
            chk("sentDat", sentDat, m_tx ? 64'hAA : 64'hFF);
            if (e_wr) begin
                chk("memWrRow", memWrRow, m_row);
                chk("memWrDat", memWrDat, m_dat);
            end
        end
        if (memWrEn) begin
            cap_row = memWrRow;
            cap_dat = memWrDat;
        end
        if (transTrig && nRxTx && cap_first_tx < 0) cap_first_tx = cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd();
        int r;
        cmdRunTrig = 1'b1;
        r = cyc;
        cancel_from(r + 1);
        sched(r + 1, K_TRIG);
        sched(r + 1, K_DONE0);
        sched(r + 1, K_FAIL0);
        sched(r + 1, K_TX0);
        cap_first_tx = -1;
        step();
        cmdRunTrig = 1'b0;
    endtask

    task automatic byte_done(input logic [7:0] b, output int d);
        repeat ($urandom_range(4, 1)) step();
        receiveDat = b;
        ByteTransDone = 1'b1;
        d = cyc;
        step();
        ByteTransDone = 1'b0;
        receiveDat = 8'($urandom);
    endtask

    task automatic end_cmd();
        int e;
        endCmd = 1'b1;
        e = cyc;
        cancel_from(e + 1);
        sched(e + 1, K_TX0);
        step();
        endCmd = 1'b0;
    endtask

    task automatic clr_aa();
        clrAA = 1'b1;
        sched(cyc + 1, K_AA0);
        step();
        clrAA = 1'b0;
    endtask

    // one full authorization exchange; the model decides accept/reject from the command rules
    task automatic copy(input logic [7:0] t1, input logic [7:0] t2, input logic [7:0] e,
                        output int d3, output bit acc);
        int d;
        run_cmd();
        byte_done(t1, d);
        sched(d + 1, K_TRIG);
        byte_done(t2, d);
        sched(d + 1, K_TRIG);
        byte_done(e, d3);
        acc = (t1 == TA1) && (t2 == TA2) && (e == 8'h07) && (ES == 3'd7) && wrSpValid &&
              (TA2 == 8'h00) && (TA1 <= 8'h87);
        if (acc) begin
            m_row = 5'(TA1 / 8);
            m_dat = Scratchpad;
            sched(d3 + 1, K_WR);
            sched(d3 + 1, K_AA1);
            sched(d3 + T + 2, K_TRIG);
            sched(d3 + T + 2, K_DONE1);
            sched(d3 + T + 2, K_TX1);
        end else begin
            sched(d3 + 1, K_FAIL1);
            sched(d3 + 1, K_DONE0);
        end
    endtask

    task automatic tx_bytes(input int d3, input int n);
        int d;
        while (cyc < d3 + T + 2) step();
        repeat (n) begin
            byte_done(8'($urandom), d);
            sched(d + 1, K_TRIG);
        end
    endtask

    initial begin
        int  d3;
        bit  acc;
        int  d;
        logic [7:0] t1, t2, e;

        repeat (3) step();
        chk("reset_sentDat", sentDat, 8'hFF);
        chk("reset_cmdDone", cmdDone, 1'b1);
        nRst = 1'b1;
        step();

        TA1 = 8'h08; TA2 = 8'h00; ES = 3'd7; wrSpValid = 1'b1;
        Scratchpad = {$urandom, $urandom};
        copy(8'h08, 8'h00, 8'h07, d3, acc);
        chk("t1_model_accept", acc, 1'b1);
        tx_bytes(d3, 3);
        chk("t1_row", cap_row, 5'd1);
        chk("t1_dat", cap_dat, Scratchpad);
        chk("t1_aa_latency", cap_first_tx - d3, 22);
        chk("t1_tx_byte", sentDat, 8'hAA);
        chk("t1_cmdDone", cmdDone, 1'b1);
        end_cmd();
        repeat (3) step();

        copy(8'h08, 8'h00, 8'h06, d3, acc);
        repeat (T + 5) step();
        chk("t2_failed", cmdFailed, 1'b1);
        chk("t2_no_tx", cap_first_tx, -1);

        TA1 = 8'h80;
        Scratchpad = {$urandom, $urandom};
        Scratchpad[7:0] = 8'h55;
        copy(8'h80, 8'h00, 8'h07, d3, acc);
        tx_bytes(d3, 2);
        chk("t3_row16", cap_row, 5'd16);
        chk("t3_dat_lsb", cap_dat[7:0], 8'h55);
        end_cmd();

        TA1 = 8'h88;
        copy(8'h88, 8'h00, 8'h07, d3, acc);
        repeat (5) step();
        chk("t4_failed", cmdFailed, 1'b1);

        clr_aa();
        TA1 = 8'h08; wrSpValid = 1'b0;
        copy(8'h08, 8'h00, 8'h07, d3, acc);
        repeat (5) step();
        chk("t5_aa", aaFlag, 1'b0);
        chk("t5_failed", cmdFailed, 1'b1);
        wrSpValid = 1'b1;

        copy(8'h08, 8'h00, 8'h07, d3, acc);
        while (cyc < d3 + 7) step();
        end_cmd();
        repeat (T + 10) step();
        chk("t6_aa", aaFlag, 1'b1);
        chk("t6_no_tx", cap_first_tx, -1);
        clr_aa();
        step();
        chk("t6_clr", aaFlag, 1'b0);

        run_cmd();
        byte_done(8'h08, d);
        sched(d + 1, K_TRIG);
        step();
        end_cmd();
        repeat (3) step();
        Scratchpad = {$urandom, $urandom};
        copy(8'h08, 8'h00, 8'h07, d3, acc);
        tx_bytes(d3, 2);
        chk("t7_row", cap_row, 5'd1);
        chk("t7_dat", cap_dat, Scratchpad);
        end_cmd();

        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(4, 0))
                0: TA1 = 8'h08;
                1: TA1 = 8'h80;
                2: TA1 = 8'h87;
                3: TA1 = 8'h88;
                default: TA1 = 8'($urandom);
            endcase
            TA2 = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00;
            ES = ($urandom_range(3, 0) == 0) ? 3'($urandom) : 3'd7;
            wrSpValid = ($urandom_range(4, 0) != 0);
            Scratchpad = {$urandom, $urandom};
            t1 = ($urandom_range(4, 0) == 0) ? 8'($urandom) : TA1;
            t2 = ($urandom_range(4, 0) == 0) ? 8'($urandom) : TA2;
            e  = ($urandom_range(4, 0) == 0) ? 8'($urandom_range(7, 0)) : 8'h07;
            copy(t1, t2, e, d3, acc);
            if (acc) begin
                if ($urandom_range(2, 0) == 0) begin
                    repeat ($urandom_range(T, 1)) step();
                    end_cmd();
                end else begin
                    tx_bytes(d3, $urandom_range(3, 1));
                    if ($urandom_range(1, 0) == 0) end_cmd();
                end
            end else begin
                repeat ($urandom_range(6, 2)) step();
            end
            if ($urandom_range(2, 0) == 0) clr_aa();
        end

        end_cmd();
        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
